sigma_delta_dac_mc: RTL
=======================

Name: sigma_delta_dac_mc

Overview:
Multi-channel sigma-delta audio DAC, the parametrised successor to the single-channel 10-bit dac used on the core's AUDIO_L/AUDIO_R pins. It takes CHANNELS samples of WIDTH bits and holds them per channel. It drives one PDM bit per channel, using a first-order or second-order modulator selected at runtime. It also presents each held sample left-justified to 16 bits for the HDMI/I2S DAC_L/DAC_R path.

Parameters:
WIDTH, 10, sample width per channel (4..16)
CHANNELS, 2, number of independent channels (1..8)

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous reset, active-high
sample_in  in  CHANNELS*WIDTH  packed samples; channel c at bits [c*WIDTH +: WIDTH]
sample_stb  in  1  one-cycle strobe; latch all channels
is_signed  in  1  1: sample_in is two's complement; 0: offset binary
order2  in  1  1: second-order modulator; 0: first-order
mute  in  1  force midscale on all channels
dac_out  out  CHANNELS  PDM bit per channel, registered
dac_pcm  out  CHANNELS*16  per channel: effective sample left-justified, i.e. {eff, (16-WIDTH) zeros}

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately:
  - held[c] = MID = 2^(WIDTH-1)
  - dac_out = 0
  - all integrators and accumulators = 0
  - order2_q = 0
- Sample latch: when sample_stb is high, held[c] <= is_signed ? {~s[W-1], s[W-2:0]} : s.
  - The conversion uses the is_signed value sampled in the strobe cycle.
  - Without sample_stb, held[c] is retained.
- Effective sample: eff[c] = mute ? MID : held[c]. This is combinational from mute.
- dac_pcm[c] = {eff[c], zeros}. It updates the cycle after the strobe, and combinationally with mute.
- Latency: strobe in cycle n, held valid at n+1, first dac_out bit from the new value at n+2.
- First-order mode (order2_q=0):
  - acc[c] is WIDTH bits.
  - sum = {1'b0,acc} + {1'b0,eff}; acc <= sum[W-1:0]; dac_out[c] <= sum[W].
  - The density of ones is exactly eff/2^W over every 2^W-cycle window that starts from acc=0.
- Second-order mode (order2_q=1):
  - i1 and i2 are signed, WIDTH+4 bits each.
  - xc = eff - MID.
  - fb = dac_out[c] ? +MID : -MID, using the currently registered output bit.
  - i1n = sat(i1 + xc - fb); i2n = sat(i2 + i1n - fb).
  - i1 <= i1n; i2 <= i2n; dac_out[c] <= (i2n >= 0).
  - sat() clamps to the signed range of WIDTH+4 bits. Integrators never wrap.
- Mode change:
  - order2 is registered into order2_q.
  - In the cycle where order2 != order2_q, all acc, i1 and i2 of every channel clear to 0. dac_out is forced to 0 for that cycle.
  - The new mode runs from the following cycle.
- Channels are fully independent. There is no shared state apart from the control inputs.
- A strobe arriving while mute is high still updates held. The new value takes effect when mute deasserts.

Test Plan:
1. Reset (W=10, C=2): assert reset asynchronously mid-stream -> dac_out=00 immediately; dac_pcm = 0x8000 on both channels; held = 512.
2. First-order, unsigned: strobe ch0=256, ch1=768 from reset state -> over the next 1024 cycles ch0 emits exactly 256 ones (one in every 4), ch1 exactly 768; dac_pcm ch0=0x4000, ch1=0xC000.
3. Signed input:
   - Strobe 0x200 with is_signed=1 -> held 0, dac_out[0] stays 0, dac_pcm=0x0000.
   - Strobe 0x1FF -> held 1023, 1023 ones per 1024 cycles, dac_pcm=0xFFC0.
4. Mute: held=1000, mute=1 -> dac_pcm=0x8000 the same cycle; exactly 512 ones per 1024 cycles. Strobe 100 during mute, then release -> density 100/1024.
5. Second-order: order2=1, ch0=384 -> ones count over 4096 cycles is 1536±16. Rail inputs 0 and 1023 for 10k cycles -> no integrator wrap, recovery to 384 density within 256 cycles.
6. Mode switch mid-stream: toggle order2 -> next cycle all integrators are 0 and dac_out=0. The first-order density is exact over the following 1024 cycles.

Source files
------------

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel sigma-delta audio DAC: per-channel held samples, runtime-selectable
// first/second-order PDM modulators, and a 16-bit left-justified PCM view of each sample.
module sigma_delta_dac_mc #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic                      sample_stb,
  input  logic                      is_signed,
  input  logic                      order2,
  input  logic                      mute,
  output logic [CHANNELS-1:0]       dac_out,
  output logic [CHANNELS*16-1:0]    dac_pcm
);

  localparam int IW = WIDTH + 4;
  localparam int EW = IW + 2;
  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [IW-1:0] IMAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] IMIN = {1'b1, {(IW-1){1'b0}}};
  localparam logic signed [EW-1:0] EMAX = {2'b00, IMAX};
  localparam logic signed [EW-1:0] EMIN = {2'b11, IMIN};
  localparam logic signed [EW-1:0] EMID = {{(EW-WIDTH){1'b0}}, MID};

  // Integrators clamp at the rails so an overloaded loop recovers instead of wrapping.
  function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > EMAX) begin
      return IMAX;
    end else if (v < EMIN) begin
      return IMIN;
    end else begin
      return v[IW-1:0];
    end
  endfunction

  logic r_order2;
  logic w_modeChange;

  assign w_modeChange = order2 ^ r_order2;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_order2 <= 1'b0;
    end else begin
      r_order2 <= order2;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0]        r_held;
    logic [WIDTH-1:0]        r_acc;
    logic signed [IW-1:0]    r_i1;
    logic signed [IW-1:0]    r_i2;
    logic                    r_bit;

    logic [WIDTH-1:0]        w_raw;
    logic [WIDTH-1:0]        w_conv;
    logic [WIDTH-1:0]        w_eff;
    logic [WIDTH+15:0]       w_pcmWide;
    logic [WIDTH:0]          w_sum;
    logic signed [EW-1:0]    w_effS;
    logic signed [EW-1:0]    w_xc;
    logic signed [EW-1:0]    w_fb;
    logic signed [EW-1:0]    w_i1Sum;
    logic signed [EW-1:0]    w_i2Sum;
    logic signed [IW-1:0]    w_i1n;
    logic signed [IW-1:0]    w_i2n;

    assign w_raw  = sample_in[c*WIDTH +: WIDTH];
    // Flipping the MSB maps two's complement onto offset binary around MID.
    assign w_conv = is_signed ? {~w_raw[WIDTH-1], w_raw[WIDTH-2:0]} : w_raw;
    assign w_eff  = mute ? MID : r_held;

    assign w_pcmWide            = {w_eff, 16'h0000};
    assign dac_pcm[c*16 +: 16]  = w_pcmWide[WIDTH+15 -: 16];

    assign w_sum = {1'b0, r_acc} + {1'b0, w_eff};

    assign w_effS  = {{(EW-WIDTH){1'b0}}, w_eff};
    assign w_xc    = w_effS - EMID;
    assign w_fb    = r_bit ? EMID : -EMID;
    assign w_i1Sum = {{2{r_i1[IW-1]}}, r_i1} + w_xc - w_fb;
    assign w_i1n   = sat(w_i1Sum);
    assign w_i2Sum = {{2{r_i2[IW-1]}}, r_i2} + {{2{w_i1n[IW-1]}}, w_i1n} - w_fb;
    assign w_i2n   = sat(w_i2Sum);

    // A mode change flushes all loop state so the new modulator starts clean.
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        r_held <= MID;
        r_acc  <= '0;
        r_i1   <= '0;
        r_i2   <= '0;
        r_bit  <= 1'b0;
      end else begin
        if (sample_stb) begin
          r_held <= w_conv;
        end
        if (w_modeChange) begin
          r_acc <= '0;
          r_i1  <= '0;
          r_i2  <= '0;
          r_bit <= 1'b0;
        end else if (r_order2) begin
          r_i1  <= w_i1n;
          r_i2  <= w_i2n;
          r_bit <= ~w_i2n[IW-1];
        end else begin
          r_acc <= w_sum[WIDTH-1:0];
          r_bit <= w_sum[WIDTH];
        end
      end
    end

    assign dac_out[c] = r_bit;
  end

endmodule
